// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants: active-low gfedcba glyphs used by both the
// multiplexed driver and the receive-side demux.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    SEL_IDLE    = 2'd0,
    SEL_ONEHOT  = 2'd1,
    SEL_ILLEGAL = 2'd2
  } sel_class_t;

endpackage

// File: rtl/sevenseg_demux_if.sv
// Snooped display bus plus reconstructed per-digit results.
interface sevenseg_demux_if #(parameter int N = 2);
  import sevenseg_pkg::*;

  seg_t                seg_in;
  logic [N-1:0]        dig_in;
  logic [N-1:0][6:0]   digit_seg;
  logic [N-1:0][3:0]   digit_hex;
  logic [N-1:0]        digit_valid;
  logic                frame_done;
  logic                err;

  modport master (
    output seg_in, dig_in,
    input  digit_seg, digit_hex, digit_valid, frame_done, err
  );

  modport slave (
    input  seg_in, dig_in,
    output digit_seg, digit_hex, digit_valid, frame_done, err
  );

endinterface

// File: rtl/sevenseg_decode.sv
// Combinational glyph decoder: active-low pattern to hex nibble plus legality.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] hex_o,
  output logic       valid_o
);

  // Table match; unknown patterns (including blank) fall through to 0/invalid.
  always_comb begin
    hex_o   = 4'h0;
    valid_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      hex_o   = (seg_i == SEG_GLYPH[i]) ? 4'(i) : hex_o;
      valid_o = (seg_i == SEG_GLYPH[i]) ? 1'b1  : valid_o;
    end
  end

endmodule

// File: rtl/sevenseg_demux.sv
// Receive-side demux for a multiplexed seven-segment bus: stability-qualified
// per-digit capture, glyph decode, frame completion and illegal-select flag.
module sevenseg_demux
  import sevenseg_pkg::*;
#(
  parameter int N             = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  sevenseg_demux_if.slave  bus
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

  seg_t              seg_q, seg_prev_q;
  logic [N-1:0]      dig_q, dig_prev_q;
  logic [RW-1:0]     run_q, run_d;
  logic [N-1:0]      seen_q, seen_d;
  logic [N-1:0][6:0] digit_seg_q;
  logic [N-1:0][3:0] digit_hex_q;
  logic [N-1:0]      digit_valid_q;
  logic              frame_done_q, frame_d;
  logic              err_q;

  sel_class_t        cls_s;
  logic [N-1:0]      sel_s;
  logic [IW-1:0]     idx_s;
  logic              same_s;
  logic              latch_s;
  logic [3:0]        dec_hex_s;
  logic              dec_valid_s;

  sevenseg_decode u_decode (
    .seg_i   (seg_q),
    .hex_o   (dec_hex_s),
    .valid_o (dec_valid_s)
  );

  // Select classification, dwell run length and latch/frame decisions.
  always_comb begin
    sel_s  = ~dig_q;
    idx_s  = '0;
    cls_s  = SEL_IDLE;
    run_d  = '0;
    if (sel_s == '0) begin
      cls_s = SEL_IDLE;
    end else if ((sel_s & (sel_s - N'(1))) == '0) begin
      cls_s = SEL_ONEHOT;
    end else begin
      cls_s = SEL_ILLEGAL;
    end
    for (int i = 0; i < N; i++) begin
      idx_s = sel_s[i] ? IW'(i) : idx_s;
    end
    same_s = (seg_q == seg_prev_q) && (dig_q == dig_prev_q);
    case (cls_s)
      SEL_ONEHOT: run_d = !same_s ? RW'(1) :
                          (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
      default:    run_d = '0;
    endcase
    // Latch exactly once per dwell: on the cycle the run first reaches the limit.
    latch_s = (run_d == RUN_MAX) && (run_q != RUN_MAX);
    seen_d  = seen_q | (N'(1) << idx_s);
    frame_d = latch_s && (&seen_d);
  end

  // Input registers, run tracking and per-digit capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q         <= SEG_BLANK;
      dig_q         <= '1;
      seg_prev_q    <= SEG_BLANK;
      dig_prev_q    <= '1;
      run_q         <= '0;
      seen_q        <= '0;
      digit_seg_q   <= {N{SEG_BLANK}};
      digit_hex_q   <= '0;
      digit_valid_q <= '0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      seg_q        <= bus.seg_in;
      dig_q        <= bus.dig_in;
      seg_prev_q   <= seg_q;
      dig_prev_q   <= dig_q;
      run_q        <= run_d;
      err_q        <= (cls_s == SEL_ILLEGAL);
      frame_done_q <= frame_d;
      if (latch_s) begin
        digit_seg_q[idx_s]   <= seg_q;
        digit_hex_q[idx_s]   <= dec_hex_s;
        digit_valid_q[idx_s] <= dec_valid_s;
        seen_q               <= frame_d ? '0 : seen_d;
      end
    end
  end

  assign bus.digit_seg   = digit_seg_q;
  assign bus.digit_hex   = digit_hex_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_sevenseg_demux.sv
// Randomized and directed bench for sevenseg_demux against a sample-history model.
module tb_sevenseg_demux;

  localparam int N  = 2;
  localparam int SC = 4;

  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sevenseg_demux_if #(.N(N)) bus ();

  sevenseg_demux #(.N(N), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int dut_frames = 0;
  int dut_err_cycles = 0;

  // Model: history of registered samples, most recent last.
  logic [6:0]        hs_seg [$];
  logic [N-1:0]      hs_dig [$];
  logic [N-1:0][6:0] m_seg;
  logic [N-1:0][3:0] m_hex;
  logic [N-1:0]      m_valid;
  logic [N-1:0]      m_seen;
  logic              m_frame;
  logic              m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] d);
    int zeros = 0;
    int k = -1;
    for (int i = 0; i < N; i++) begin
      if (!d[i]) begin
        zeros++;
        k = i;
      end
    end
    return (zeros == 1) ? k : -1;
  endfunction

  task automatic model_step();
    if (reset) begin
      hs_seg.delete();
      hs_dig.delete();
      hs_seg.push_back(7'h7F);
      hs_dig.push_back('1);
      m_seg   = {N{7'h7F}};
      m_hex   = '0;
      m_valid = '0;
      m_seen  = '0;
      m_frame = 1'b0;
      m_err   = 1'b0;
    end else begin
      int last = hs_seg.size() - 1;
      logic [6:0]   ls = hs_seg[last];
      logic [N-1:0] ld = hs_dig[last];
      int k = onehot_idx(ld);
      int len = 0;
      if (k >= 0) begin
        for (int i = last; i >= 0; i--) begin
          if (hs_seg[i] == ls && hs_dig[i] == ld) len++;
          else break;
        end
      end
      m_err   = (k < 0) && (ld != '1);
      m_frame = 1'b0;
      if (k >= 0 && len == SC) begin
        m_seg[k]   = ls;
        m_hex[k]   = 4'h0;
        m_valid[k] = 1'b0;
        for (int g = 0; g < 16; g++) begin
          if (GLY[g] == ls) begin
            m_hex[k]   = 4'(g);
            m_valid[k] = 1'b1;
          end
        end
        m_seen[k] = 1'b1;
        if (&m_seen) begin
          m_frame = 1'b1;
          m_seen  = '0;
        end
      end
      hs_seg.push_back(bus.seg_in);
      hs_dig.push_back(bus.dig_in);
      if (hs_seg.size() > SC + 2) begin
        void'(hs_seg.pop_front());
        void'(hs_dig.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("digit_seg",   32'(bus.digit_seg),   32'(m_seg));
    chk("digit_hex",   32'(bus.digit_hex),   32'(m_hex));
    chk("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
    chk("frame_done",  32'(bus.frame_done),  32'(m_frame));
    chk("err",         32'(bus.err),         32'(m_err));
    dut_frames     += int'(bus.frame_done);
    dut_err_cycles += int'(bus.err);
  endtask

  task automatic hold(input logic [N-1:0] d, input logic [6:0] s, input int n);
    bus.dig_in = d;
    bus.seg_in = s;
    repeat (n) tick();
  endtask

  initial begin
    int f0;
    int e0;
    logic [3:0] v0, v1;
    reset      = 1'b1;
    bus.seg_in = 7'($urandom);
    bus.dig_in = N'($urandom);

    // Reset with random pins.
    repeat (3) begin
      bus.seg_in = 7'($urandom);
      bus.dig_in = N'($urandom);
      tick();
    end
    chk("rst_seg",   32'(bus.digit_seg),   32'h3FFF);
    chk("rst_hex",   32'(bus.digit_hex),   32'h0);
    chk("rst_valid", 32'(bus.digit_valid), 32'h0);
    chk("rst_frame", 32'(bus.frame_done),  32'h0);
    chk("rst_err",   32'(bus.err),         32'h0);
    reset = 1'b0;
    hold('1, 7'h7F, 2);

    // Two-digit frame.
    f0 = dut_frames;
    hold(2'b10, 7'h30, 6);
    chk("tdf_hex0", 32'(bus.digit_hex[0]), 32'h3);
    hold(2'b01, 7'h24, 6);
    chk("tdf_hex",   32'(bus.digit_hex),   32'h23);
    chk("tdf_valid", 32'(bus.digit_valid), 32'h3);
    chk("tdf_frames", 32'(dut_frames - f0), 32'd1);

    // Ghost rejection.
    f0 = dut_frames;
    hold(2'b01, 7'h00, 3);
    hold('1, 7'h7F, 3);
    chk("ghost_hex", 32'(bus.digit_hex), 32'h23);
    chk("ghost_seg", 32'(bus.digit_seg), 32'(14'h1230));
    chk("ghost_frames", 32'(dut_frames - f0), 32'd0);

    // Illegal select.
    e0 = dut_err_cycles;
    hold(2'b00, 7'h30, 2);
    hold('1, 7'h7F, 3);
    chk("ill_err_cycles", 32'(dut_err_cycles - e0), 32'd2);
    chk("ill_hex", 32'(bus.digit_hex), 32'h23);

    // Unknown glyph, then rewrite of the same digit.
    f0 = dut_frames;
    hold(2'b10, 7'h7F, 5);
    chk("unk_valid0", 32'(bus.digit_valid[0]), 32'h0);
    chk("unk_hex0",   32'(bus.digit_hex[0]),   32'h0);
    hold(2'b10, 7'h79, 5);
    chk("rw_hex0",   32'(bus.digit_hex[0]),   32'h1);
    chk("rw_valid0", 32'(bus.digit_valid[0]), 32'h1);
    chk("rw_frames", 32'(dut_frames - f0), 32'd0);

    // Reset mid-frame, then a full frame.
    hold(2'b10, 7'h19, 6);
    reset = 1'b1;
    hold('1, 7'h7F, 2);
    reset = 1'b0;
    f0 = dut_frames;
    hold(2'b10, 7'h12, 6);
    chk("rmf_nofr", 32'(dut_frames - f0), 32'd0);
    hold(2'b01, 7'h02, 6);
    chk("rmf_frames", 32'(dut_frames - f0), 32'd1);
    chk("rmf_hex", 32'(bus.digit_hex), 32'h65);

    // Driver-style loopback: 8-cycle dwell per digit.
    f0 = dut_frames;
    v0 = 4'h0;
    v1 = 4'h0;
    for (int fr = 0; fr < 4; fr++) begin
      v0 = 4'($urandom);
      v1 = 4'($urandom);
      hold(2'b10, GLY[v0], 8);
      hold(2'b01, GLY[v1], 8);
    end
    chk("lb_frames", 32'(dut_frames - f0), 32'd4);
    chk("lb_hex", 32'(bus.digit_hex), 32'({v1, v0}));
    chk("lb_valid", 32'(bus.digit_valid), 32'h3);

    // Randomized dwells with occasional resets.
    for (int t = 0; t < 400; t++) begin
      logic [N-1:0] d;
      logic [6:0]   s;
      int r = int'($urandom_range(0, 99));
      if (r < 60) d = ~(N'(1) << $urandom_range(0, N - 1));
      else if (r < 80) d = '1;
      else d = N'($urandom);
      s = ($urandom_range(0, 9) < 7) ? GLY[$urandom_range(0, 15)] : 7'($urandom);
      reset = ($urandom_range(0, 99) < 3);
      hold(d, s, int'($urandom_range(1, 7)));
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_demux.md
# sevenseg_demux

Receive-side counterpart of the multiplexed seven-segment driver. It snoops an active-low segment bus and an active-low one-hot digit-select bus, and qualifies each digit dwell by stability. It reconstructs the per-digit segment patterns and decodes each one back to a hex nibble. It sits in loopback/self-test paths and in benches that check display output, and flags illegal select patterns and completed display frames.

## Interface
- `N`, 2, number of digits; must equal the driver's digit count; N ≥ 2.
- `STABLE_CYCLES`, 4, consecutive identical registered samples required before a digit is latched; ≥ 2.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous reset, active-high.
- `seg_in`  in  7  active-low segments, bit 0 = a … bit 6 = g.
- `dig_in`  in  N  active-low one-hot digit select; all-ones = blank.
- `digit_seg`  out  N×7  last latched raw pattern per digit.
- `digit_hex`  out  N×4  decoded nibble per digit.
- `digit_valid`  out  N  per digit: latched pattern is a legal hex glyph.
- `frame_done`  out  1  one-cycle pulse: every digit latched since the previous pulse or reset.
- `err`  out  1  high for each cycle the registered select is illegal.

## Operation
- Input stage: `seg_in` and `dig_in` are registered every cycle into `seg_q` and `dig_q`. All logic below works on these registered copies.
- `dig_q` classification:
  - IDLE: all ones.
  - ONEHOT: exactly one zero, at index k.
  - ILLEGAL: anything else.
- Run counter:
  - It counts consecutive cycles in which {`seg_q`, `dig_q`} equals the previous cycle's value and the class is ONEHOT.
  - Any change, IDLE or ILLEGAL resets the run to 1 (ONEHOT) or 0 (otherwise).
  - The counter saturates.
- Latch: when the run reaches `STABLE_CYCLES`, digit k is written once per dwell:
  - `digit_seg[k]` ← `seg_q`; `digit_hex[k]` and `digit_valid[k]` ← decode of `seg_q`; `seen[k]` ← 1.
  - No re-latch until the run is broken.
- Decode (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - Any other pattern, including blank 7F: hex=0, valid=0.
- Frame tracking:
  - When a latch makes `seen` all ones, `frame_done` pulses and `seen` clears to all zeros.
  - A digit latched twice before the frame completes overwrites its data; `seen` is unchanged.
- `err`: registered; high for every cycle after a cycle in which `dig_q` was ILLEGAL. An ILLEGAL sample breaks the run and does not touch `seen`.
- Reset (any time, including mid-dwell or mid-frame):
  - `digit_seg` = all 7F; `digit_hex` = 0; `digit_valid` = 0; `frame_done` = 0; `err` = 0.
  - Run counter = 0, `seen` = 0, `seg_q` = 7F, `dig_q` = all ones.
  - Partial frames are discarded.

## Timing
- Let E0 be the first edge that registers new pin values.
- If the pins are held through edge E0+STABLE_CYCLES−1, then `digit_*[k]` update at edge E0+STABLE_CYCLES. Pin-to-output latency is therefore STABLE_CYCLES+1 edges after the pins change.
- A dwell shorter than STABLE_CYCLES samples is ignored entirely (ghost rejection).
- `frame_done` asserts on the same edge as the completing latch and lasts exactly one cycle.
- `err` asserts one edge after the illegal sample is registered.
- Only one digit can latch per cycle.
- When latch and frame completion coincide, `seen` ends at zero and the latched digit is not carried into the next frame.
- Outputs hold their values indefinitely while input is IDLE.

## Structure
- Shared package `sevenseg_pkg` holds:
  - localparam array `SEG_GLYPH[16]` of active-low patterns;
  - `SEG_BLANK` = 7'h7F;
  - the `seg_t` typedef (logic [6:0]).
- The driver and this block both take glyph constants from `sevenseg_pkg`.
- Sub-module `sevenseg_decode`: combinational, `seg_t` in → {hex[3:0], valid}. It is instantiated once on `seg_q`.
- Run counter width: $clog2(STABLE_CYCLES+1).

## Test plan
- **Reset values:** reset for 3 cycles with random pins → `digit_seg` all 7F, `digit_hex` 0, `valid`/`frame_done`/`err` 0.
- **Two-digit frame (N=2, STABLE_CYCLES=4):**
  - Stimulus: dig=10, seg=30 held for 6 cycles, then dig=01, seg=24 held for 6 cycles.
  - Response: `digit_hex[0]`=3 at E0+4; `digit_hex[1]`=2 with `valid`=11; `frame_done` pulses once, on the digit-1 latch edge.
- **Ghost rejection:** dig=01, seg=00 held for 3 cycles, then IDLE → no output change, no `frame_done`.
- **Illegal select:** dig=00 for 2 cycles → `err` high for 2 cycles, one cycle delayed; `seen` and outputs untouched.
- **Unknown glyph and rewrite:**
  - Stimulus: seg=7F on digit 0 for 5 cycles, then seg=79 on digit 0 for 5 cycles.
  - Response: first `valid[0]`=0, `hex`=0; then `hex[0]`=1, `valid[0]`=1; no `frame_done`.
- **Reset mid-frame and driver loopback:**
  - Reset after digit 0 latches, then run a full frame → exactly one `frame_done`, after both digits.
  - Loopback with the mux driver, driver enable every 8 cycles → `digit_hex` matches driven values; one `frame_done` per 16 cycles.
